pipeline_controller: RTL
========================

# pipeline_controller

Hazard and stall sequencer for the 5-stage RISC-V pipeline. It drives the enable and flush controls of the pc and the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves three causes in priority order: data-memory wait, taken branch or jump in EX, and load-use hazard in ID. A watchdog bounds every memory wait.

## Interface
Parameters:
- `REG_ADDR_W`, default 5: register-index width.
- `TIMEOUT`, default 255: maximum number of frozen memory-wait cycles; must be at least 1.
- `PERF_W`, default 16: width of the performance counters.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `id_rs1`, `id_rs2`  in  REG_ADDR_W  source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2`  in  1  the ID instruction actually reads that source.
- `ex_rd`  in  REG_ADDR_W  destination register of the instruction in EX.
- `ex_mem_read`  in  1  the EX instruction is a load.
- `ex_branch_taken`  in  1  a branch or jump resolved taken in EX.
- `mem_req`  in  1  the MEM instruction accesses data memory.
- `mem_ack`  in  1  data memory completes the access this cycle.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en`  out  1  stage load enables.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush`  out  1  load a bubble (NOP) instead of d.
- `mem_err`  out  1  registered pulse: the memory wait ended by timeout.
- `stall_cycles`, `flush_count`  out  PERF_W  performance counters (see Configuration).

## Operation
- States: RUN, MEM_WAIT.
- All enable and flush outputs are combinational (Mealy) from the state and the current inputs.
- Memory freeze: all five enables are 0, `mem_wb_flush` is 1, and all other flushes are 0.
  - A freeze occurs when (RUN and `mem_req` and not `mem_ack`), or in MEM_WAIT when not `mem_ack` and the wait counter is below TIMEOUT.
  - A freeze overrides branch and load-use handling.
- Branch flush (no freeze, `ex_branch_taken`=1):
  - All enables are 1.
  - `if_id_flush`=1 and `id_ex_flush`=1.
- Load-use stall (no freeze, no branch):
  - Condition: `ex_mem_read` and `ex_rd`!=0, and ((`id_uses_rs1` and `id_rs1`==`ex_rd`) or (`id_uses_rs2` and `id_rs2`==`ex_rd`)).
  - Outputs: `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1.
  - All other enables are 1 and all other flushes are 0.
- Otherwise, all enables are 1 and all flushes are 0.
- Simultaneous branch and load-use: the branch wins, because the ID instruction is on the wrong path.
- FSM transitions:
  - RUN goes to MEM_WAIT on `mem_req` and not `mem_ack`; the wait counter is set to 1.
  - MEM_WAIT goes to RUN on `mem_ack`.
  - MEM_WAIT also goes to RUN when the counter equals TIMEOUT (forced release).
  - Otherwise MEM_WAIT stays and the counter increments.
- Release cycle (the MEM_WAIT cycle with `mem_ack`, or the forced release): the memory freeze no longer applies, and branch and load-use rules are evaluated normally.
- `mem_err` is set on the edge that enters the forced-release cycle and is cleared on the next edge. It is high for exactly that release cycle.
- A forced release leaves any late `mem_ack` ignored while in RUN unless `mem_req` is high.

## Timing
- Zero-wait access (`mem_req` and `mem_ack` in the same RUN cycle): no stall.
- A miss produces N+1 frozen cycles, where N is the number of MEM_WAIT cycles before the ack. The cap is TIMEOUT frozen cycles, counting the RUN detection cycle.
- Each load-use stall is exactly 1 cycle, because the load leaves EX on the next edge.
- Reset (`rst_n`=0 at an edge):
  - State becomes RUN, the wait counter 0, `mem_err` 0, and the counters 0.
  - While `rst_n` is low, outputs are forced: enables 0, flushes 1.
- A reset in the middle of MEM_WAIT abandons the wait with no `mem_err`.
- The wait counter is wide enough to hold TIMEOUT, computed as clog2(TIMEOUT+1).

## Configuration
- `PIPELINE_CTRL_PERF_EN` defined:
  - `stall_cycles` counts cycles with `pc_en`=0.
  - `flush_count` counts cycles with `if_id_flush`=1.
  - Both counters saturate at all-ones and are cleared by reset.
- Macro undefined: both ports are present but tied to 0, and no counter flops are synthesized.

## Structure
- Shared package `pipeline_ctrl_pkg`:
  - state enum (RUN, MEM_WAIT);
  - default TIMEOUT;
  - the NOP encoding used by the bubble-inserting registers.
- Sub-module `load_use_detect`: combinational comparator producing the load-use hazard flag, reused by a future forwarding unit.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5, `id_uses_rs1`=1 -> for 1 cycle `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1; then back to all enables 1.
- `ex_rd`=0 with a load, and matching `id_rs1`=0 -> no stall.
- Simultaneous branch and load-use -> `if_id_flush`=1, `id_ex_flush`=1, `pc_en`=1.
- `mem_req`=1, `mem_ack` arrives on the 3rd cycle -> 2 frozen cycles with `mem_wb_flush`=1; release cycle has all enables 1 and `mem_err`=0.
- `TIMEOUT`=4, `mem_ack` never arrives -> exactly 4 frozen cycles, then a forced release with `mem_err`=1 for 1 cycle; state returns to RUN.
- `rst_n` low during MEM_WAIT -> next cycle is RUN with counter 0. With `PIPELINE_CTRL_PERF_EN`, `stall_cycles` and `flush_count` read 0 after reset and saturate at 0xFFFF under sustained stall.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall sequencer.
package pipeline_ctrl_pkg;

  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StMemWait = 1'b1
  } ctrl_state_e;

  // Default cap on frozen memory-wait cycles.
  localparam int unsigned DefaultTimeout = 255;

  // addi x0, x0, 0: the bubble loaded by flushed stage registers.
  localparam logic [31:0] NopInstr = 32'h0000_0013;

endpackage

// File: rtl/pipeline_controller_if.sv
// Hazard inputs, stage controls and perf counters of the pipeline controller.
interface pipeline_controller_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned PERF_W     = 16
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_mem_read;
  logic                  ex_branch_taken;
  logic                  mem_req;
  logic                  mem_ack;
  logic                  pc_en;
  logic                  if_id_en;
  logic                  id_ex_en;
  logic                  ex_mem_en;
  logic                  mem_wb_en;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  mem_wb_flush;
  logic                  mem_err;
  logic [PERF_W-1:0]     stall_cycles;
  logic [PERF_W-1:0]     flush_count;

  // Pipeline side: supplies hazard info, consumes controls.
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ack,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush, mem_err, stall_cycles, flush_count
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_req, mem_ack,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, mem_wb_flush, mem_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator between the ID sources and the EX load.
module load_use_detect #(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  hazard
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is never a real dependency, so a load to x0 cannot stall.
  always_comb begin
    rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
    rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);
    hazard  = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipeline_controller.sv
// Hazard and stall sequencer for the 5-stage pipeline: memory freeze with watchdog,
// branch flush and load-use stall, in that priority.
// Optional perf counters are built when PIPELINE_CTRL_PERF_EN is defined.
module pipeline_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned TIMEOUT    = DefaultTimeout,
  parameter int unsigned PERF_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_controller_if.slave bus
);

  localparam int unsigned    CntW       = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  ctrl_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_err_q, mem_err_d;
  logic            freeze;
  logic            load_use;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, mem_wb_flush;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .id_uses_rs1 (bus.id_uses_rs1),
    .id_uses_rs2 (bus.id_uses_rs2),
    .ex_rd       (bus.ex_rd),
    .ex_mem_read (bus.ex_mem_read),
    .hazard      (load_use)
  );

  // State, wait counter and timeout pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next-state logic and freeze decision for the memory wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    freeze  = 1'b0;
    case (state_q)
      StRun: begin
        if (bus.mem_req && !bus.mem_ack) begin
          freeze  = 1'b1;
          state_d = StMemWait;
          cnt_d   = CntW'(1);
        end
      end
      StMemWait: begin
        if (bus.mem_ack || (cnt_q == TimeoutCnt)) begin
          // Release cycle: ack arrived or the watchdog forces the pipeline on.
          state_d = StRun;
          cnt_d   = '0;
        end else begin
          freeze = 1'b1;
          cnt_d  = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StRun;
        cnt_d   = '0;
      end
    endcase
    // High during the cycle the wait counter sits at the cap, i.e. the forced release.
    mem_err_d = (state_d == StMemWait) && (cnt_d == TimeoutCnt);
  end

  // Stage enables and flushes, Mealy on state and current hazards.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (!rst_n) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      {if_id_flush, id_ex_flush, mem_wb_flush}          = '1;
    end else if (freeze) begin
      {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = '0;
      mem_wb_flush = 1'b1;
    end else if (bus.ex_branch_taken) begin
      // Branch beats load-use: the ID instruction is on the wrong path anyway.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.if_id_en     = if_id_en;
  assign bus.id_ex_en     = id_ex_en;
  assign bus.ex_mem_en    = ex_mem_en;
  assign bus.mem_wb_en    = mem_wb_en;
  assign bus.if_id_flush  = if_id_flush;
  assign bus.id_ex_flush  = id_ex_flush;
  assign bus.mem_wb_flush = mem_wb_flush;
  assign bus.mem_err      = mem_err_q;

`ifdef PIPELINE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_q;
  logic [PERF_W-1:0] flush_q;

  // Saturating counters of stalled-pc cycles and IF/ID flush cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && (stall_q != '1)) stall_q <= stall_q + PERF_W'(1);
      if (if_id_flush && (flush_q != '1)) flush_q <= flush_q + PERF_W'(1);
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
`else
  assign bus.stall_cycles = '0;
  assign bus.flush_count  = '0;
`endif

endmodule
